// File: rtl/uart_packet_rx.sv
// uart_packet_rx: sync-hunting framed packet parser (cmd, len, payload, XOR checksum)
// holding one validated packet in a buffer until acknowledged.
module uart_packet_rx #(
    parameter int MAX_LEN = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int TIMEOUT_CLKS = 12000,
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [7:0]    rx_byte_i,
    input  logic          byte_available_i,
    output logic [7:0]    pkt_cmd_o,
    output logic [7:0]    pkt_len_o,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          pkt_ready_o,
    input  logic          pkt_ack_i,
    output logic          err_o,
    output logic [1:0]    err_code_o
);
    typedef enum logic [2:0] {S_SYNC, S_CMD, S_LEN, S_PAYLOAD, S_CSUM, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d, csum_q, csum_d, cmd_q, cmd_d, len_q, len_d;
    logic [7:0]  pcmd_q, pcmd_d, plen_q, plen_d, rd_data_q;
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d, wr_en;
    logic [1:0]  code_q, code_d;
    logic [7:0]  mem [MAX_LEN];

    wire bv = byte_available_i;
    wire [7:0] rx = rx_byte_i;
    wire counting = (state_q != S_SYNC) && (state_q != S_HOLD);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        pcmd_d  = pcmd_q;
        plen_d  = plen_q;
        err_d   = 1'b0;
        code_d  = code_q;
        wr_en   = 1'b0;
        tmo_d   = bv ? 16'd0 : tmo_q;
        case (state_q)
            S_SYNC: if (bv && rx == SYNC_BYTE) begin
                state_d = S_CMD;
                csum_d  = 8'd0;
                idx_d   = 8'd0;
            end
            S_CMD: if (bv) begin
                cmd_d   = rx;
                csum_d  = csum_q ^ rx;
                state_d = S_LEN;
            end
            S_LEN: if (bv) begin
                len_d   = rx;
                csum_d  = csum_q ^ rx;
                state_d = (rx > 8'(MAX_LEN)) ? S_SYNC : (rx == 8'd0) ? S_CSUM : S_PAYLOAD;
                err_d   = rx > 8'(MAX_LEN);
                code_d  = (rx > 8'(MAX_LEN)) ? 2'b01 : code_q;
            end
            S_PAYLOAD: if (bv) begin
                wr_en   = 1'b1;
                csum_d  = csum_q ^ rx;
                idx_d   = (idx_q + 8'd1 == len_q) ? 8'd0 : idx_q + 8'd1;
                state_d = (idx_q + 8'd1 == len_q) ? S_CSUM : S_PAYLOAD;
            end
            S_CSUM: if (bv) begin
                state_d = (rx == csum_q) ? S_HOLD : S_SYNC;
                err_d   = rx != csum_q;
                code_d  = (rx == csum_q) ? code_q : 2'b10;
                pcmd_d  = (rx == csum_q) ? cmd_q : pcmd_q;
                plen_d  = (rx == csum_q) ? len_q : plen_q;
            end
            S_HOLD: begin
                // an ack in the same cycle as a byte frees us to treat it as a sync candidate
                if (pkt_ack_i) begin
                    state_d = (bv && rx == SYNC_BYTE) ? S_CMD : S_SYNC;
                    csum_d  = 8'd0;
                    idx_d   = 8'd0;
                end else if (bv) begin
                    err_d  = 1'b1;
                    code_d = 2'b00;
                end
            end
            default: state_d = S_SYNC;
        endcase
        if (counting && !bv) begin
            if (tmo_q == 16'(TIMEOUT_CLKS - 1)) begin
                err_d   = 1'b1;
                code_d  = 2'b11;
                state_d = S_SYNC;
                tmo_d   = 16'd0;
                idx_d   = 8'd0;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_SYNC;
            idx_q     <= '0;
            csum_q    <= '0;
            cmd_q     <= '0;
            len_q     <= '0;
            pcmd_q    <= '0;
            plen_q    <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            pcmd_q    <= pcmd_d;
            plen_q    <= plen_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            code_q    <= code_d;
            rd_data_q <= (32'(rd_addr_i) >= MAX_LEN) ? 8'h00 : mem[rd_addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[idx_q[AW-1:0]] <= rx;
    end

    assign pkt_cmd_o   = pcmd_q;
    assign pkt_len_o   = plen_q;
    assign rd_data_o   = rd_data_q;
    assign pkt_ready_o = state_q == S_HOLD;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
endmodule

// File: tb/tb_uart_packet_rx.sv
// tb_uart_packet_rx: directed self-checking bench for uart_packet_rx.
module tb_uart_packet_rx;
    localparam int TMO = 12000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       byte_available = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic       pkt_ack = 1'b0;
    logic [7:0] pkt_cmd, pkt_len, rd_data;
    logic       pkt_ready, err;
    logic [1:0] err_code;
    int         n_checks = 0, n_fail = 0, err_cnt = 0, saved;

    uart_packet_rx #(.MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .rx_byte_i(rx_byte), .byte_available_i(byte_available),
        .pkt_cmd_o(pkt_cmd), .pkt_len_o(pkt_len), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .pkt_ready_o(pkt_ready), .pkt_ack_i(pkt_ack), .err_o(err), .err_code_o(err_code)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (err) err_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b;
        byte_available = 1'b1;
        tick();
        byte_available = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        tick();
        check(tag, rd_data, exp);
    endtask

    task automatic ack();
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
        check("ack_release", pkt_ready, 0);
    endtask

    task automatic expect_err(input string tag, input logic [1:0] code);
        check({tag, "_err"}, err, 1);
        check({tag, "_code"}, err_code, code);
        tick();
        check({tag, "_err_1cyc"}, err, 0);
        check({tag, "_code_hold"}, err_code, code);
    endtask

    initial begin
        int n;
        logic [7:0] big[$];
        repeat (3) tick();
        check("rst_ready", pkt_ready, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check("rst_cmd", pkt_cmd, 0);
        check("rst_len", pkt_len, 0);
        check("rst_rd", rd_data, 0);
        rst_n = 1'b1;
        tick();

        saved = err_cnt;
        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33});
        check("p1_not_yet", pkt_ready, 0);
        send(8'h13);
        check("p1_ready", pkt_ready, 1);
        check("p1_cmd", pkt_cmd, 8'h10);
        check("p1_len", pkt_len, 3);
        rd("p1_rd0", 0, 8'h11);
        rd("p1_rd1", 1, 8'h22);
        rd("p1_rd2", 2, 8'h33);
        check("p1_noerr", err_cnt, saved);
        ack();

        send_seq('{8'h00, 8'hFF, 8'hA5, 8'h42, 8'h00, 8'h42});
        check("p2_ready", pkt_ready, 1);
        check("p2_cmd", pkt_cmd, 8'h42);
        check("p2_len", pkt_len, 0);
        ack();

        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14});
        check("bad_cs_ready", pkt_ready, 0);
        check("bad_cs_cmd_kept", pkt_cmd, 8'h42);
        expect_err("bad_cs", 2'b10);
        send_seq('{8'hA5, 8'h07, 8'h01, 8'h09, 8'h0F});
        check("p3_ready", pkt_ready, 1);
        check("p3_cmd", pkt_cmd, 8'h07);
        rd("p3_rd0", 0, 8'h09);
        ack();

        send_seq('{8'hA5, 8'h10, 8'h11});
        expect_err("bad_len", 2'b01);
        saved = err_cnt;
        send_seq('{8'h10, 8'h00, 8'h10});
        check("bad_len_discard", pkt_ready, 0);
        check("bad_len_quiet", err_cnt, saved);

        big = '{8'hA5, 8'h01, 8'h10};
        for (int i = 0; i < 16; i++) big.push_back(8'h80 | 8'(i));
        big.push_back(8'h11);
        send_seq(big);
        check("max_ready", pkt_ready, 1);
        check("max_len", pkt_len, 16);
        rd("max_rd0", 0, 8'h80);
        rd("max_rd15", 15, 8'h8F);
        ack();

        send_seq('{8'hA5, 8'h10});
        n = 0;
        while (!err && n < TMO + 20) begin
            tick();
            n++;
        end
        check("tmo_latency", n, TMO);
        expect_err("tmo", 2'b11);
        send_seq('{8'hA5, 8'h10, 8'h00, 8'h10});
        check("tmo_next_ready", pkt_ready, 1);
        ack();

        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});
        send(8'h55);
        check("ovr_ready", pkt_ready, 1);
        check("ovr_cmd", pkt_cmd, 8'h10);
        expect_err("ovr", 2'b00);
        rd("ovr_rd1", 1, 8'h22);
        saved = err_cnt;
        pkt_ack = 1'b1;
        send(8'hA5);
        pkt_ack = 1'b0;
        check("ackbyte_ready", pkt_ready, 0);
        send_seq('{8'h20, 8'h00, 8'h20});
        check("ackbyte_pkt", pkt_ready, 1);
        check("ackbyte_cmd", pkt_cmd, 8'h20);
        check("ackbyte_noerr", err_cnt, saved);
        ack();

        send_seq('{8'hA5, 8'h01, 8'h20});
        expect_err("len32", 2'b01);
        send_seq('{8'hA5, 8'h30, 8'h04, 8'h01, 8'h02});
        rst_n = 1'b0;
        tick();
        check("mid_rst_ready", pkt_ready, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_code", err_code, 0);
        check("mid_rst_cmd", pkt_cmd, 0);
        check("mid_rst_len", pkt_len, 0);
        check("mid_rst_rd", rd_data, 0);
        rst_n = 1'b1;
        tick();
        send_seq('{8'h03, 8'h04, 8'h30});
        check("mid_rst_discard", pkt_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
